// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 counter display path: command bytes,
// FSM encodings, the byte-request payload and small helper functions.
package lcd_pkg;

    // HD44780 command and data constants
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display, needs the long wait
    localparam logic [7:0] LCD_ENTRY    = 8'h06;  // entry mode: increment, no shift
    localparam logic [7:0] LCD_DDRAM0   = 8'h80;  // set DDRAM address 0
    localparam logic [7:0] ASCII_ZERO   = 8'h30;

    localparam int unsigned INIT_BYTES  = 4;
    localparam int unsigned WRITE_BYTES = 4;
    localparam int unsigned CONV_STEPS  = 8;
    localparam int unsigned BCD_W       = 20;  // 3 BCD nibbles + 8 binary bits

    // Top-level sequencer states
    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_CONV,
        ST_WRITE
    } lcd_state_e;

    // Byte-writer phases
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_EHIGH,
        PH_WAIT
    } wr_phase_e;

    // One byte to put on the LCD bus
    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        logic       long_wait;
    } lcd_byte_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Init command sequence, indexed by byte number
    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        unique case (idx)
            2'd0: b = LCD_FUNC_SET;
            2'd1: b = LCD_DISP_ON;
            2'd2: b = LCD_CLEAR;
            2'd3: b = LCD_ENTRY;
        endcase
        return b;
    endfunction

    // One shift-add-3 step: adjust each BCD nibble >= 5, then shift left
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] a;
        a = s;
        for (int i = 0; i < 3; i++) begin
            if (a[8+4*i +: 4] >= 4'd5) begin
                a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
            end
        end
        return {a[BCD_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/lcd_count_writer_byte.sv
// lcd_byte_writer: puts one byte on the HD44780 bus with setup, E-high and
// post-E wait timing.
//   clk, rst    : clock, synchronous active-high reset
//   start, req  : accept a byte (honoured when idle or in the last wait cycle)
//   done        : high during the last wait cycle of a byte
//   idle        : no byte in flight
//   lcd_rs/e/db : LCD bus outputs (registered)
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_E_CYC   = 25,
    parameter int unsigned T_CMD_CYC = 2500,
    parameter int unsigned T_CLR_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  lcd_byte_t  req,
    output logic       done,
    output logic       idle,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    localparam int unsigned MAX_CYC = max_u(T_E_CYC, max_u(T_CMD_CYC, T_CLR_CYC));
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    wr_phase_e        phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic [7:0]       db_q, db_d;
    logic             long_q, long_d;
    logic             done_q, done_d;
    logic             idle_q, idle_d;

    // Phase register
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            long_q  <= 1'b0;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            long_q  <= long_d;
            done_q  <= done_d;
            idle_q  <= idle_d;
        end
    end

    // Next phase; RS/DB are only reloaded when a byte is accepted (setup cycle)
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        rs_d    = rs_q;
        db_d    = db_q;
        long_d  = long_q;

        unique case (phase_q)
            PH_IDLE: begin
                if (start) begin
                    phase_d = PH_SETUP;
                    rs_d    = req.rs;
                    db_d    = req.data;
                    long_d  = req.long_wait;
                end
            end
            PH_SETUP: begin
                phase_d = PH_EHIGH;
                e_d     = 1'b1;
                cnt_d   = CNT_W'(T_E_CYC - 1);
            end
            PH_EHIGH: begin
                if (cnt_q == '0) begin
                    phase_d = PH_WAIT;
                    e_d     = 1'b0;
                    cnt_d   = long_q ? CNT_W'(T_CLR_CYC - 1) : CNT_W'(T_CMD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PH_WAIT: begin
                if (cnt_q == '0) begin
                    // Back-to-back bytes: next setup follows the last wait cycle directly
                    if (start) begin
                        phase_d = PH_SETUP;
                        rs_d    = req.rs;
                        db_d    = req.data;
                        long_d  = req.long_wait;
                    end else begin
                        phase_d = PH_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase

        done_d = (phase_d == PH_WAIT) && (cnt_d == '0);
        idle_d = (phase_d == PH_IDLE);
    end

    assign done   = done_q;
    assign idle   = idle_q;
    assign lcd_rs = rs_q;
    assign lcd_e  = e_q;
    assign lcd_db = db_q;

endmodule

// File: rtl/lcd_count_writer.sv
// lcd_count_writer: shows an 8-bit value as three decimal digits on an
// HD44780 character LCD over the 8-bit parallel bus.
//   CLK, RST      : clock, synchronous active-high reset
//   VALUE, UPDATE : value to show and its one-cycle request strobe
//   BUSY          : low only while idle and ready for a new value
//   LCD_RS/RW/E/DB: LCD bus (RW tied low, write only)
module lcd_count_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP_CYC = 2000000,
    parameter int unsigned T_E_CYC     = 25,
    parameter int unsigned T_CMD_CYC   = 2500,
    parameter int unsigned T_CLR_CYC   = 100000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] VALUE,
    input  logic       UPDATE,
    output logic       BUSY,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DB
);

    localparam int unsigned PWR_W = $clog2(T_PWRUP_CYC + 1);

    lcd_state_e       state_q, state_d;
    logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       conv_cnt_q, conv_cnt_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [7:0]       value_q, value_d;
    logic             pending_q, pending_d;
    logic             busy_q, busy_d;

    logic             wr_start_c;
    lcd_byte_t        wr_req_c;
    logic [7:0]       wr_byte_c;
    logic             wr_done, wr_idle, wr_ready_c;
    logic             upd_pend_c;
    logic [7:0]       upd_val_c;

    lcd_byte_writer #(
        .T_E_CYC   (T_E_CYC),
        .T_CMD_CYC (T_CMD_CYC),
        .T_CLR_CYC (T_CLR_CYC)
    ) u_byte_writer (
        .clk    (CLK),
        .rst    (RST),
        .start  (wr_start_c),
        .req    (wr_req_c),
        .done   (wr_done),
        .idle   (wr_idle),
        .lcd_rs (LCD_RS),
        .lcd_e  (LCD_E),
        .lcd_db (LCD_DB)
    );

    assign wr_ready_c = wr_idle | wr_done;
    // A strobe on the finishing cycle counts as pending, and its value wins
    assign upd_pend_c = pending_q | UPDATE;
    assign upd_val_c  = UPDATE ? VALUE : value_q;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_PWRUP;
            pwr_cnt_q  <= '0;
            idx_q      <= 3'd0;
            conv_cnt_q <= 3'd0;
            bcd_q      <= '0;
            value_q    <= 8'h00;
            pending_q  <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            pwr_cnt_q  <= pwr_cnt_d;
            idx_q      <= idx_d;
            conv_cnt_q <= conv_cnt_d;
            bcd_q      <= bcd_d;
            value_q    <= value_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and byte sequencing
    always_comb begin
        state_d    = state_q;
        pwr_cnt_d  = pwr_cnt_q;
        idx_d      = idx_q;
        conv_cnt_d = conv_cnt_q;
        bcd_d      = bcd_q;
        value_d    = value_q;
        pending_d  = pending_q;
        wr_start_c = 1'b0;
        wr_req_c   = '0;
        wr_byte_c  = 8'h00;

        if (UPDATE) begin
            value_d = VALUE;
            if (state_q != ST_IDLE) begin
                pending_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_PWRUP: begin
                if (pwr_cnt_q == PWR_W'(T_PWRUP_CYC - 1)) begin
                    state_d = ST_INIT;
                    idx_d   = 3'd0;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
                end
            end
            ST_INIT, ST_WRITE: begin
                if (wr_ready_c) begin
                    if (idx_q < 3'(INIT_BYTES)) begin
                        if (state_q == ST_INIT) begin
                            wr_byte_c = init_byte(idx_q[1:0]);
                            wr_req_c.rs = 1'b0;
                        end else begin
                            unique case (idx_q[1:0])
                                2'd0: wr_byte_c = LCD_DDRAM0;
                                2'd1: wr_byte_c = ASCII_ZERO + {4'h0, bcd_q[19:16]};
                                2'd2: wr_byte_c = ASCII_ZERO + {4'h0, bcd_q[15:12]};
                                2'd3: wr_byte_c = ASCII_ZERO + {4'h0, bcd_q[11:8]};
                            endcase
                            wr_req_c.rs = (idx_q != 3'd0);
                        end
                        wr_req_c.data      = wr_byte_c;
                        wr_req_c.long_wait = (wr_byte_c == LCD_CLEAR);
                        wr_start_c         = 1'b1;
                        idx_d              = idx_q + 3'd1;
                    end else if (upd_pend_c) begin
                        // Last byte's wait is ending: serve the pending request directly
                        pending_d  = 1'b0;
                        state_d    = ST_CONV;
                        bcd_d      = {12'h000, upd_val_c};
                        conv_cnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (UPDATE) begin
                    state_d    = ST_CONV;
                    bcd_d      = {12'h000, VALUE};
                    conv_cnt_d = 3'd0;
                end
            end
            ST_CONV: begin
                bcd_d = dd_step(bcd_q);
                if (conv_cnt_q == 3'(CONV_STEPS - 1)) begin
                    state_d = ST_WRITE;
                    idx_d   = 3'd0;
                end else begin
                    conv_cnt_d = conv_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_PWRUP;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign BUSY   = busy_q;
    assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_count_writer.sv
// Directed bench for lcd_count_writer: a bus monitor pops expected bytes
// from a scoreboard queue and checks E width, E-low gaps and bus stability.
module tb_lcd_count_writer;

    localparam int unsigned T_PWRUP = 100;
    localparam int unsigned T_E     = 4;
    localparam int unsigned T_CMD   = 20;
    localparam int unsigned T_CLR   = 50;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] VALUE;
    logic       UPDATE;
    logic       BUSY;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_E;
    logic [7:0] LCD_DB;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         gap;   // expected E-low samples before this pulse, 0 = unchecked
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_bytes  = 0;
    int last_fall = 0;

    lcd_count_writer #(
        .T_PWRUP_CYC (T_PWRUP),
        .T_E_CYC     (T_E),
        .T_CMD_CYC   (T_CMD),
        .T_CLR_CYC   (T_CLR)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .VALUE  (VALUE),
        .UPDATE (UPDATE),
        .BUSY   (BUSY),
        .LCD_RS (LCD_RS),
        .LCD_RW (LCD_RW),
        .LCD_E  (LCD_E),
        .LCD_DB (LCD_DB)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor
    logic       e_prev    = 1'b0;
    int         high_cnt  = 0;
    logic       bad_high  = 1'b0;
    logic [8:0] bus_prev  = 9'h000;
    int         chg_cyc   = -1;
    logic       fell_ok   = 1'b0;

    always @(negedge CLK) begin
        if (RST) begin
            e_prev   = 1'b0;
            high_cnt = 0;
            bad_high = 1'b0;
            bus_prev = 9'h000;
            chg_cyc  = -1;
            fell_ok  = 1'b0;
        end else begin
            if ({LCD_RS, LCD_DB} !== bus_prev) begin
                if (LCD_E) bad_high = 1'b1;
                else       chg_cyc  = cyc;
            end
            if (LCD_E && !e_prev) begin
                n_bytes++;
                high_cnt = 1;
                n_assert++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_byte: observed rs=%0b db=%02h expected no byte", LCD_RS, LCD_DB);
                end
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("byte_rs", 32'(LCD_RS), 32'(mon_e.rs));
                    check("byte_db", 32'(LCD_DB), 32'(mon_e.db));
                    if (mon_e.gap > 0 && fell_ok) check("e_low_gap", 32'(cyc - last_fall), 32'(mon_e.gap));
                end
                // Bus may only change in the single setup cycle before E rises
                check("bus_change_outside_setup", 32'(chg_cyc >= 0 && chg_cyc != cyc - 1), 32'd0);
            end else if (LCD_E) begin
                high_cnt++;
            end
            if (!LCD_E && e_prev) begin
                check("e_width", 32'(high_cnt), 32'(T_E));
                check("bus_stable_e_high", 32'(bad_high), 32'd0);
                check("rw_low", 32'(LCD_RW), 32'd0);
                last_fall = cyc;
                fell_ok   = 1'b1;
                chg_cyc   = -1;
                bad_high  = 1'b0;
            end
            bus_prev = {LCD_RS, LCD_DB};
            e_prev   = LCD_E;
        end
    end

    task automatic push(input logic rs, input logic [7:0] db, input int gap);
        exp_t e;
        e.rs = rs; e.db = db; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38, 0);
        push(1'b0, 8'h0C, T_CMD + 1);
        push(1'b0, 8'h01, T_CMD + 1);
        push(1'b0, 8'h06, T_CLR + 1);
    endtask

    task automatic push_value(input int v);
        push(1'b0, 8'h80, 0);
        push(1'b1, 8'(8'h30 + v / 100), T_CMD + 1);
        push(1'b1, 8'(8'h30 + (v / 10) % 10), T_CMD + 1);
        push(1'b1, 8'(8'h30 + v % 10), T_CMD + 1);
    endtask

    task automatic send_update(input logic [7:0] v);
        @(negedge CLK);
        VALUE  = v;
        UPDATE = 1'b1;
        @(posedge CLK);
        #1;
        UPDATE = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && BUSY !== 1'b0; i++) @(negedge CLK);
        check(tag, 32'(BUSY), 32'd0);
    endtask

    task automatic wait_e_high(input string tag);
        for (int i = 0; i < 3000 && LCD_E !== 1'b1; i++) @(negedge CLK);
        check(tag, 32'(LCD_E), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_e"},    32'(LCD_E),  32'd0);
        check({tag, "_rs"},   32'(LCD_RS), 32'd0);
        check({tag, "_rw"},   32'(LCD_RW), 32'd0);
        check({tag, "_db"},   32'(LCD_DB), 32'h00);
        check({tag, "_busy"}, 32'(BUSY),   32'd1);
    endtask

    initial begin
        int rel;
        int acc;
        int nb;

        RST    = 1'b1;
        UPDATE = 1'b0;
        VALUE  = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");

        // 1: power-up wait and init sequence
        push_init();
        @(negedge CLK);
        RST = 1'b0;
        rel = cyc;
        wait_e_high("init_first_e");
        check("pwrup_bus_idle", 32'((cyc - rel) > T_PWRUP), 32'd1);
        wait_idle("init_done");
        check("busy_fall_after_wait", 32'(cyc - last_fall), 32'(T_CMD));
        check("init_sb_empty", 32'(exp_q.size()), 32'd0);
        nb = n_bytes;
        repeat (40) @(negedge CLK);
        check("blank_after_init", 32'(n_bytes - nb), 32'd0);

        // 2: single update, 173
        push_value(173);
        send_update(8'd173);
        check("busy_rise", 32'(BUSY), 32'd1);
        acc = cyc;
        wait_e_high("upd173_e");
        // 8 conversion cycles, one cycle issuing the byte, one setup cycle
        check("conv_latency", 32'(cyc - acc), 32'd10);
        wait_idle("upd173_done");

        // 3: boundary values
        push_value(0);
        send_update(8'd0);
        wait_idle("upd0_done");
        push_value(255);
        send_update(8'd255);
        wait_idle("upd255_done");
        check("boundary_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4: strobes while busy collapse to one update with the latest value
        push_value(100);
        send_update(8'd100);
        wait_e_high("upd100_e");
        send_update(8'd5);
        repeat (30) @(negedge CLK);
        send_update(8'd9);
        push_value(9);
        wait_idle("pending_done");
        nb = n_bytes;
        repeat (60) @(negedge CLK);
        check("single_extra_update", 32'(n_bytes - nb), 32'd0);
        check("pending_sb_empty", 32'(exp_q.size()), 32'd0);

        // Strobe on the very edge that would re-enter IDLE
        push_value(12);
        send_update(8'd12);
        nb = n_bytes;
        for (int i = 0; i < 3000 && n_bytes < nb + 4; i++) @(negedge CLK);
        check("edge_case_bytes", 32'(n_bytes - nb), 32'd4);
        for (int i = 0; i < 100 && LCD_E !== 1'b0; i++) @(negedge CLK);
        repeat (T_CMD - 1) @(negedge CLK);
        VALUE  = 8'd34;
        UPDATE = 1'b1;
        @(posedge CLK);
        #1;
        UPDATE = 1'b0;
        check("busy_held_on_idle_entry", 32'(BUSY), 32'd1);
        push_value(34);
        wait_idle("edge_case_done");
        check("edge_case_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: reset while E is high, then 6: strobe during power-up
        push_value(77);
        send_update(8'd77);
        wait_e_high("pre_reset_e");
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check_reset_outputs("mid_byte_reset");
        exp_q.delete();
        push_init();
        push_value(42);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        rel = cyc;
        repeat (10) @(negedge CLK);
        check("busy_in_pwrup", 32'(BUSY), 32'd1);
        send_update(8'd42);
        wait_e_high("reinit_first_e");
        check("reinit_pwrup_idle", 32'((cyc - rel) > T_PWRUP), 32'd1);
        wait_idle("reinit_done");
        check("reinit_sb_empty", 32'(exp_q.size()), 32'd0);
        nb = n_bytes;
        repeat (40) @(negedge CLK);
        check("no_bytes_after_reinit", 32'(n_bytes - nb), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
